// File: rtl/mpu6050_pkg.sv
// Shared widths, coefficient derivation and saturation helper for the
// MPU6050 raw-count to fixed-point scaler.
package mpu6050_pkg;

    localparam int DEF_ACC_WIDTH             = 16;
    localparam int DEF_GYRO_WIDTH            = 16;
    localparam int DEF_ACC_SENS_COEFF_WIDTH  = 16;
    localparam int DEF_GYRO_SENS_COEFF_WIDTH = 16;
    localparam int RAW_WIDTH                 = 16;

    localparam real PI = 3.14159265358979323846;

    // Coefficients are signed Q2.(2*cw-2), so the final shift is 2*cw-2.
    function automatic int shift_of(input int cw);
        return 2 * cw - 2;
    endfunction

    // 0.25 g/LSB-scaled: 16384 LSB/g into Q4.12 is a factor of 1/4.
    function automatic longint k_acc_of(input int cw);
        return longint'(1) <<< (shift_of(cw) - 2);
    endfunction

    // 131 LSB per deg/s, converted to rad/s and scaled into Q4.12.
    function automatic longint k_gyro_of(input int cw);
        real r;
        r = (PI / 180.0) / 131.0 * 4096.0 * (2.0 ** shift_of(cw));
        return longint'(r);
    endfunction

    // Clamp a wide signed value to the signed range of a w-bit result.
    function automatic logic signed [127:0] sat_to(input logic signed [127:0] v,
                                                   input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/mpu6050_axis_scale.sv
// One axis: raw count times constant coefficient, round half-up, shift,
// saturate and register, exposing the full-precision intermediates.
module mpu6050_axis_scale
    import mpu6050_pkg::*;
#(
    parameter int     IN_W    = 16,
    parameter int     OUT_W   = 16,
    parameter int     COEFF_W = 16,
    parameter longint K       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [IN_W-1:0]            sens,
    output logic signed [OUT_W-1:0]           scaled,
    output logic signed [2*COEFF_W+IN_W-1:0]  temp,
    output logic signed [2*COEFF_W+IN_W:0]    rounded
);

    localparam int TW = 2 * COEFF_W + IN_W;
    localparam int RW = TW + 1;
    localparam int S  = shift_of(COEFF_W);

    localparam logic signed [2*COEFF_W-1:0] COEFF = K[2*COEFF_W-1:0];
    localparam logic signed [RW-1:0]        HALF  = {{(RW-1){1'b0}}, 1'b1} << (S - 1);

    logic signed [TW-1:0]    temp_next;
    logic signed [RW-1:0]    rounded_next;
    logic signed [RW-1:0]    shifted;
    logic signed [127:0]     sat_wide;
    logic signed [OUT_W-1:0] scaled_next;

    logic signed [TW-1:0]    temp_reg;
    logic signed [RW-1:0]    rounded_reg;
    logic signed [OUT_W-1:0] scaled_reg;

    // Multiply, add half an output LSB, arithmetic shift, then clamp.
    always_comb begin
        temp_next    = TW'(sens) * TW'(COEFF);
        rounded_next = {temp_next[TW-1], temp_next} + HALF;
        shifted      = rounded_next >>> S;
        sat_wide     = sat_to(128'(shifted), OUT_W);
        scaled_next  = sat_wide[OUT_W-1:0];
    end

    // Single output stage; reset clears the result and both debug values.
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_reg    <= '0;
            rounded_reg <= '0;
            scaled_reg  <= '0;
        end else begin
            temp_reg    <= temp_next;
            rounded_reg <= rounded_next;
            scaled_reg  <= scaled_next;
        end
    end

    assign temp    = temp_reg;
    assign rounded = rounded_reg;
    assign scaled  = scaled_reg;

endmodule

// File: rtl/mpu6050.sv
// Six-axis MPU6050 scaler: three accel axes and three gyro axes, each an
// independent registered multiply/round/saturate lane.
module mpu6050
    import mpu6050_pkg::*;
#(
    parameter int ACC_WIDTH             = DEF_ACC_WIDTH,
    parameter int GYRO_WIDTH            = DEF_GYRO_WIDTH,
    parameter int ACC_SENS_COEFF_WIDTH  = DEF_ACC_SENS_COEFF_WIDTH,
    parameter int GYRO_SENS_COEFF_WIDTH = DEF_GYRO_SENS_COEFF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic [15:0] a_x_sens,
    input  logic [15:0] a_y_sens,
    input  logic [15:0] a_z_sens,
    input  logic [15:0] w_x_sens,
    input  logic [15:0] w_y_sens,
    input  logic [15:0] w_z_sens,
    output logic [ACC_WIDTH-1:0]  a_x,
    output logic [ACC_WIDTH-1:0]  a_y,
    output logic [ACC_WIDTH-1:0]  a_z,
    output logic [GYRO_WIDTH-1:0] w_x,
    output logic [GYRO_WIDTH-1:0] w_y,
    output logic [GYRO_WIDTH-1:0] w_z,
    output logic [2*ACC_SENS_COEFF_WIDTH+15:0]  a_x_temp_debug,
    output logic [2*ACC_SENS_COEFF_WIDTH+15:0]  a_y_temp_debug,
    output logic [2*ACC_SENS_COEFF_WIDTH+15:0]  a_z_temp_debug,
    output logic [2*ACC_SENS_COEFF_WIDTH+16:0]  a_x_rounded_debug,
    output logic [2*ACC_SENS_COEFF_WIDTH+16:0]  a_y_rounded_debug,
    output logic [2*ACC_SENS_COEFF_WIDTH+16:0]  a_z_rounded_debug,
    output logic [2*GYRO_SENS_COEFF_WIDTH+15:0] w_x_temp_debug,
    output logic [2*GYRO_SENS_COEFF_WIDTH+15:0] w_y_temp_debug,
    output logic [2*GYRO_SENS_COEFF_WIDTH+15:0] w_z_temp_debug,
    output logic [2*GYRO_SENS_COEFF_WIDTH+16:0] w_x_rounded_debug,
    output logic [2*GYRO_SENS_COEFF_WIDTH+16:0] w_y_rounded_debug,
    output logic [2*GYRO_SENS_COEFF_WIDTH+16:0] w_z_rounded_debug
);

    localparam int     CWA    = ACC_SENS_COEFF_WIDTH;
    localparam int     CWG    = GYRO_SENS_COEFF_WIDTH;
    localparam longint K_ACC  = k_acc_of(CWA);
    localparam longint K_GYRO = k_gyro_of(CWG);

    logic [15:0]          acc_sens  [3];
    logic [ACC_WIDTH-1:0] acc_out   [3];
    logic [2*CWA+15:0]    acc_temp  [3];
    logic [2*CWA+16:0]    acc_rnd   [3];

    logic [15:0]           gyro_sens [3];
    logic [GYRO_WIDTH-1:0] gyro_out  [3];
    logic [2*CWG+15:0]     gyro_temp [3];
    logic [2*CWG+16:0]     gyro_rnd  [3];

    assign acc_sens[0]  = a_x_sens;
    assign acc_sens[1]  = a_y_sens;
    assign acc_sens[2]  = a_z_sens;
    assign gyro_sens[0] = w_x_sens;
    assign gyro_sens[1] = w_y_sens;
    assign gyro_sens[2] = w_z_sens;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_acc
            mpu6050_axis_scale #(
                .IN_W(RAW_WIDTH), .OUT_W(ACC_WIDTH), .COEFF_W(CWA), .K(K_ACC)
            ) u_axis (
                .clk(clk), .rst(rst), .sens(acc_sens[gi]),
                .scaled(acc_out[gi]), .temp(acc_temp[gi]), .rounded(acc_rnd[gi])
            );
        end
        for (gi = 0; gi < 3; gi++) begin : g_gyro
            mpu6050_axis_scale #(
                .IN_W(RAW_WIDTH), .OUT_W(GYRO_WIDTH), .COEFF_W(CWG), .K(K_GYRO)
            ) u_axis (
                .clk(clk), .rst(rst), .sens(gyro_sens[gi]),
                .scaled(gyro_out[gi]), .temp(gyro_temp[gi]), .rounded(gyro_rnd[gi])
            );
        end
    endgenerate

    assign a_x = acc_out[0];
    assign a_y = acc_out[1];
    assign a_z = acc_out[2];
    assign w_x = gyro_out[0];
    assign w_y = gyro_out[1];
    assign w_z = gyro_out[2];

    assign a_x_temp_debug    = acc_temp[0];
    assign a_y_temp_debug    = acc_temp[1];
    assign a_z_temp_debug    = acc_temp[2];
    assign a_x_rounded_debug = acc_rnd[0];
    assign a_y_rounded_debug = acc_rnd[1];
    assign a_z_rounded_debug = acc_rnd[2];
    assign w_x_temp_debug    = gyro_temp[0];
    assign w_y_temp_debug    = gyro_temp[1];
    assign w_z_temp_debug    = gyro_temp[2];
    assign w_x_rounded_debug = gyro_rnd[0];
    assign w_y_rounded_debug = gyro_rnd[1];
    assign w_z_rounded_debug = gyro_rnd[2];

endmodule

// File: tb/tb_mpu6050.sv
// Directed bench for mpu6050 with hand-computed expected values.
module tb_mpu6050;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] a_x_sens = '0, a_y_sens = '0, a_z_sens = '0;
    logic [15:0] w_x_sens = '0, w_y_sens = '0, w_z_sens = '0;
    logic [15:0] a_x, a_y, a_z, w_x, w_y, w_z;
    logic [47:0] a_x_temp_debug, a_y_temp_debug, a_z_temp_debug;
    logic [48:0] a_x_rounded_debug, a_y_rounded_debug, a_z_rounded_debug;
    logic [47:0] w_x_temp_debug, w_y_temp_debug, w_z_temp_debug;
    logic [48:0] w_x_rounded_debug, w_y_rounded_debug, w_z_rounded_debug;

    int total = 0;
    int bad   = 0;

    localparam longint K_ACC = 64'sd268435456;
    localparam longint HALF  = 64'sd536870912;

    // expected scaled output per axis: 0..2 accel x/y/z, 3..5 gyro x/y/z
    longint exp_out [6];

    always #5 clk = ~clk;

    mpu6050 dut (
        .clk(clk), .rst(rst),
        .a_x_sens(a_x_sens), .a_y_sens(a_y_sens), .a_z_sens(a_z_sens),
        .w_x_sens(w_x_sens), .w_y_sens(w_y_sens), .w_z_sens(w_z_sens),
        .a_x(a_x), .a_y(a_y), .a_z(a_z), .w_x(w_x), .w_y(w_y), .w_z(w_z),
        .a_x_temp_debug(a_x_temp_debug), .a_y_temp_debug(a_y_temp_debug),
        .a_z_temp_debug(a_z_temp_debug),
        .a_x_rounded_debug(a_x_rounded_debug), .a_y_rounded_debug(a_y_rounded_debug),
        .a_z_rounded_debug(a_z_rounded_debug),
        .w_x_temp_debug(w_x_temp_debug), .w_y_temp_debug(w_y_temp_debug),
        .w_z_temp_debug(w_z_temp_debug),
        .w_x_rounded_debug(w_x_rounded_debug), .w_y_rounded_debug(w_y_rounded_debug),
        .w_z_rounded_debug(w_z_rounded_debug)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, got, exp);
    endtask

    function automatic longint out_of(input int i);
        case (i)
            0: return longint'($signed(a_x));
            1: return longint'($signed(a_y));
            2: return longint'($signed(a_z));
            3: return longint'($signed(w_x));
            4: return longint'($signed(w_y));
            default: return longint'($signed(w_z));
        endcase
    endfunction

    task automatic set_in(input int i, input logic [15:0] v);
        case (i)
            0: a_x_sens = v;
            1: a_y_sens = v;
            2: a_z_sens = v;
            3: w_x_sens = v;
            4: w_y_sens = v;
            default: w_z_sens = v;
        endcase
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_ax%0d", tag, i), out_of(i), exp_out[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // new inputs for the one-axis-per-cycle sequence, with their results
    logic [15:0] seq_in  [6] = '{16'hFB77, 16'h03CC, 16'h0F0F, 16'hFC30, 16'h078C, 16'hC3FE};
    longint      seq_exp [6] = '{-290, 243, 964, -533, 1054, -8383};

    initial begin
        // reset with nonzero inputs held for two edges
        for (int i = 0; i < 6; i++) set_in(i, 16'h1234);
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) exp_out[i] = 0;
        check_all("reset");
        check("rst_atemp", longint'($signed(a_x_temp_debug)), 0);
        check("rst_arnd",  longint'($signed(a_x_rounded_debug)), 0);
        check("rst_wtemp", longint'($signed(w_z_temp_debug)), 0);
        check("rst_wrnd",  longint'($signed(w_z_rounded_debug)), 0);

        // first edge after release gives a valid result (0x1234 = 4660)
        rst = 1'b0;
        step();
        exp_out = '{1165, 1165, 1165, 2543, 2543, 2543};
        check_all("release");

        // accel and gyro vectors
        a_x_sens = 16'hFB77; a_y_sens = 16'h0000; a_z_sens = 16'h03CC;
        w_x_sens = 16'hFC30; w_y_sens = 16'h078C; w_z_sens = 16'hC3FE;
        step();
        exp_out = '{-290, 0, 243, -533, 1054, -8383};
        check_all("vec1");
        check("ax_temp", longint'($signed(a_x_temp_debug)), -64'sd1161 * K_ACC);
        check("ax_rnd",  longint'($signed(a_x_rounded_debug)), -64'sd1161 * K_ACC + HALF);

        a_x_sens = 16'h0F0F; w_x_sens = 16'h9999;
        step();
        check("ax_964",    out_of(0), 964);
        check("wx_-14306", out_of(3), -14306);

        // extremes
        a_x_sens = 16'h8000; a_y_sens = 16'h7FFF; a_z_sens = 16'h0000;
        w_x_sens = 16'h7FFF; w_y_sens = 16'h8000; w_z_sens = 16'h0000;
        step();
        exp_out = '{-8192, 8192, 0, 17881, -17882, 0};
        check_all("extreme");

        // zero on every axis
        for (int i = 0; i < 6; i++) set_in(i, 16'h0000);
        step();
        for (int i = 0; i < 6; i++) exp_out[i] = 0;
        check_all("zero");

        // rounding ties
        a_y_sens = 16'h0002;
        step();
        check("tie_pos", out_of(1), 1);
        check("tie_pos_rnd", longint'($signed(a_y_rounded_debug)),
              longint'($signed(a_y_temp_debug)) + HALF);
        check("tie_pos_tmp", longint'($signed(a_y_temp_debug)), 64'sd2 * K_ACC);
        a_y_sens = 16'hFFFE;
        step();
        check("tie_neg", out_of(1), 0);
        check("tie_neg_rnd", longint'($signed(a_y_rounded_debug)), -64'sd2 * K_ACC + HALF);

        // one input change per cycle; only that axis moves, one edge later
        a_y_sens = 16'h0000;
        step();
        for (int i = 0; i < 6; i++) exp_out[i] = 0;
        check_all("seq_base");
        for (int k = 0; k < 6; k++) begin
            set_in(k, seq_in[k]);
            #2;
            check($sformatf("seq%0d_hold", k), out_of(k), exp_out[k]);
            step();
            exp_out[k] = seq_exp[k];
            check_all($sformatf("seq%0d", k));
        end

        // reset mid-stream overrides the sampled input on that edge
        rst = 1'b1;
        a_x_sens = 16'h0F0F;
        step();
        for (int i = 0; i < 6; i++) exp_out[i] = 0;
        check_all("midrst");
        check("midrst_wtemp", longint'($signed(w_y_temp_debug)), 0);
        rst = 1'b0;
        step();
        exp_out = '{964, 243, 964, -533, 1054, -8383};
        check_all("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
